// File: rtl/pcie_mailbox_reader.sv
// pcie_mailbox_reader
// ---------------------------------------------------------------------------
// Polls the PCIe-shared mailbox RAM for host-to-FPGA messages. Each slot is
// four 32-bit words; bit 31 of word 3 is a toggle ("lead") bit. A slot holds a
// new message when its lead bit differs from the value last delivered for that
// slot. A message is read header-first (w3), then w0..w2, then w3 again. The
// message is presented only if both w3 reads agree. If they differ, the host
// was writing while the slot was read (a torn read), so the slot is re-read.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   enable        allows the start of a new header read
//   RAM_addr      word address of the current read (held between reads)
//   RAM_rd_en     one-cycle read strobe
//   RAM_rdata     read data, valid RD_LAT cycles after RAM_rd_en
//   FPGA_data     {w3,w2,w1,w0} of the presented message
//   FPGA_valid    message available; held until FPGA_accept
//   FPGA_accept   consumer handshake
//   slot_id       slot of the presented message
//   busy          block is not in IDLE
// ---------------------------------------------------------------------------
module pcie_mailbox_reader #(
  parameter int          NSLOT     = 1,
  parameter logic [10:0] BASE_ADDR = 11'h000,
  parameter int          RD_LAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic [10:0]  RAM_addr,
  output logic         RAM_rd_en,
  input  logic [31:0]  RAM_rdata,
  output logic [127:0] FPGA_data,
  output logic         FPGA_valid,
  input  logic         FPGA_accept,
  output logic [6:0]   slot_id,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, HDR, BODY, CHK, PRESENT} state_t;

  localparam logic [1:0] LAT       = 2'(RD_LAT);
  localparam logic [6:0] LAST_SLOT = 7'(NSLOT - 1);

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;     // cycles since the last read strobe
  logic [1:0]        word_reg, word_next;   // body word being read
  logic [6:0]        slot_reg, slot_next;
  logic [1:0]        retry_reg, retry_next;
  logic [3:0][31:0]  w_reg, w_next;         // w_reg[3] is the header word
  logic              rd_en_reg, rd_en_next;
  logic [10:0]       addr_reg, addr_next;
  logic              valid_reg, valid_next;

  logic [127:0]      last_lead;
  logic              lead_set;

  logic              data_ready;
  logic [6:0]        slot_adv;
  logic              issue;
  logic [6:0]        issue_slot;
  logic [1:0]        issue_word;

  function automatic logic [10:0] slot_addr(input logic [6:0] s, input logic [1:0] w);
    return BASE_ADDR + {2'b00, s, 2'b00} + {9'b0, w};
  endfunction

  assign data_ready = (cnt_reg == LAT);
  assign slot_adv   = (slot_reg == LAST_SLOT) ? 7'd0 : slot_reg + 7'd1;

  // Per-slot lead bit last delivered. Unused slot positions read as 0 so
  // the pointer can index the vector directly.
  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_lead
      if (gi < NSLOT) begin : g_used
        logic lead_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            lead_q <= 1'b0;
          end else if (lead_set && (slot_reg == 7'(gi))) begin
            lead_q <= w_reg[3][31];
          end
        end
        assign last_lead[gi] = lead_q;
      end else begin : g_unused
        assign last_lead[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      word_reg  <= 2'd0;
      slot_reg  <= 7'd0;
      retry_reg <= 2'd0;
      w_reg     <= '0;
      rd_en_reg <= 1'b0;
      addr_reg  <= 11'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      slot_reg  <= slot_next;
      retry_reg <= retry_next;
      w_reg     <= w_next;
      rd_en_reg <= rd_en_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = data_ready ? cnt_reg : cnt_reg + 2'd1;  // saturate at LAT
    word_next  = word_reg;
    slot_next  = slot_reg;
    retry_next = retry_reg;
    w_next     = w_reg;
    rd_en_next = 1'b0;
    addr_next  = addr_reg;
    valid_next = valid_reg;
    lead_set   = 1'b0;
    issue      = 1'b0;
    issue_slot = slot_reg;
    issue_word = 2'd3;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = HDR;
          issue      = 1'b1;
        end
      end

      HDR: begin
        if (data_ready) begin
          if (RAM_rdata[31] == last_lead[slot_reg]) begin
            // Stale slot: move on without touching the body.
            slot_next  = slot_adv;
            retry_next = 2'd0;
            if (enable) begin
              issue      = 1'b1;
              issue_slot = slot_adv;
            end else begin
              state_next = IDLE;
            end
          end else begin
            w_next[3]  = RAM_rdata;
            word_next  = 2'd0;
            state_next = BODY;
            issue      = 1'b1;
            issue_word = 2'd0;
          end
        end
      end

      BODY: begin
        if (data_ready) begin
          w_next[word_reg] = RAM_rdata;
          issue            = 1'b1;
          if (word_reg == 2'd2) begin
            state_next = CHK;
          end else begin
            word_next  = word_reg + 2'd1;
            issue_word = word_reg + 2'd1;
          end
        end
      end

      CHK: begin
        if (data_ready) begin
          if (RAM_rdata == w_reg[3]) begin
            lead_set   = 1'b1;
            valid_next = 1'b1;
            state_next = PRESENT;
          end else if (retry_reg == 2'd2) begin
            // Third torn read in a row: give up on this slot for now. The
            // lead bit is left alone so the message is picked up next pass.
            retry_next = 2'd0;
            slot_next  = slot_adv;
            if (enable) begin
              state_next = HDR;
              issue      = 1'b1;
              issue_slot = slot_adv;
            end else begin
              state_next = IDLE;
            end
          end else begin
            // Re-reading the same slot finishes the current transaction,
            // so it is not gated by enable.
            retry_next = retry_reg + 2'd1;
            state_next = HDR;
            issue      = 1'b1;
          end
        end
      end

      PRESENT: begin
        if (FPGA_accept) begin
          valid_next = 1'b0;
          slot_next  = slot_adv;
          retry_next = 2'd0;
          if (enable) begin
            state_next = HDR;
            issue      = 1'b1;
            issue_slot = slot_adv;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (issue) begin
      rd_en_next = 1'b1;
      addr_next  = slot_addr(issue_slot, issue_word);
      cnt_next   = 2'd0;
    end
  end

  assign RAM_addr   = addr_reg;
  assign RAM_rd_en  = rd_en_reg;
  assign FPGA_data  = w_reg;
  assign FPGA_valid = valid_reg;
  assign slot_id    = slot_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_pcie_mailbox_reader.sv
// Testbench for pcie_mailbox_reader. Two instances are used:
//   dut_a: NSLOT=4, BASE_ADDR=0x100, RD_LAT=1
//   dut_b: NSLOT=1, BASE_ADDR=0x000, RD_LAT=2
// Expected messages are queued by the stimulus process. Independent monitors
// pop and compare the queued messages on every valid/accept handshake.
module tb_pcie_mailbox_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [6:0]   slot;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A ----------------
  logic         rst_n_a, enable_a, accept_a;
  logic [10:0]  addr_a;
  logic         rd_en_a;
  logic [31:0]  rdata_a;
  logic [127:0] data_a;
  logic         valid_a;
  logic [6:0]   slot_a;
  logic         busy_a;

  pcie_mailbox_reader #(.NSLOT(4), .BASE_ADDR(11'h100), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .enable(enable_a),
    .RAM_addr(addr_a), .RAM_rd_en(rd_en_a), .RAM_rdata(rdata_a),
    .FPGA_data(data_a), .FPGA_valid(valid_a), .FPGA_accept(accept_a),
    .slot_id(slot_a), .busy(busy_a)
  );

  // ---------------- instance B ----------------
  logic         rst_n_b, enable_b, accept_b;
  logic [10:0]  addr_b;
  logic         rd_en_b;
  logic [31:0]  rdata_b;
  logic [127:0] data_b;
  logic         valid_b;
  logic [6:0]   slot_b;
  logic         busy_b;

  pcie_mailbox_reader #(.NSLOT(1), .BASE_ADDR(11'h000), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(enable_b),
    .RAM_addr(addr_b), .RAM_rd_en(rd_en_b), .RAM_rdata(rdata_b),
    .FPGA_data(data_b), .FPGA_valid(valid_b), .FPGA_accept(accept_b),
    .slot_id(slot_b), .busy(busy_b)
  );

  // ---------------- RAM models ----------------
  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_b [0:2047];

  // Torn-read injection for A: each read of torn_addr while requests are
  // outstanding flips bit 0 of the value seen on subsequent reads.
  logic [31:0] rd1_a = '0;
  logic        flip = 1'b0;
  int          torn_req = 0;
  int          torn_done = 0;
  logic [10:0] torn_addr = '0;
  logic        cap_next = 1'b0;
  logic [10:0] after_torn_addr = '0;

  always @(posedge clk) begin
    if (rd_en_a) begin
      rd1_a <= mem_a[addr_a] ^ ((addr_a == torn_addr) ? {31'b0, flip} : 32'b0);
      if (cap_next) begin
        after_torn_addr <= addr_a;
        cap_next        <= 1'b0;
      end
      if ((torn_done < torn_req) && (addr_a == torn_addr)) begin
        flip      <= ~flip;
        torn_done <= torn_done + 1;
        if (torn_done + 1 == torn_req) cap_next <= 1'b1;
      end
    end
  end
  assign rdata_a = rd1_a;

  logic [31:0] rd1_b = '0;
  logic [31:0] rd2_b = '0;
  always @(posedge clk) begin
    if (rd_en_b) rd1_b <= mem_b[addr_b];
    rd2_b <= rd1_b;
  end
  assign rdata_b = rd2_b;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin : mon_a
    exp_t e;
    @(negedge clk);
    if (valid_a && accept_a) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_msg_a: got slot %0d data %h expected none", slot_a, data_a);
      end else begin
        e = exp_a.pop_front();
        check("msg_data_a", data_a, e.data);
        check("msg_slot_a", slot_a, e.slot);
        $display("[TB] A msg slot %0d data %h", slot_a, data_a);
      end
    end
  end

  initial forever begin : mon_b
    exp_t e;
    @(negedge clk);
    if (valid_b && accept_b) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_msg_b: got slot %0d data %h expected none", slot_b, data_b);
      end else begin
        e = exp_b.pop_front();
        check("msg_data_b", data_b, e.data);
        check("msg_slot_b", slot_b, e.slot);
        $display("[TB] B msg slot %0d data %h", slot_b, data_b);
      end
    end
  end

  // Read-address bookkeeping
  logic       legal_on = 1'b0;
  int         illegal_a = 0;
  logic [3:0] hdr_seen = '0;
  logic       b_only3 = 1'b0;
  int         illegal_b = 0;
  int         reads_b = 0;

  initial forever begin : addr_mon
    @(negedge clk);
    if (legal_on && rd_en_a) begin
      if (addr_a[1:0] == 2'b11) begin
        if (addr_a >= 11'h103 && addr_a <= 11'h10F)
          hdr_seen[(int'(addr_a) - 'h103) / 4] = 1'b1;
        else
          illegal_a++;
      end else if (!((addr_a >= 11'h104 && addr_a <= 11'h106) ||
                     (addr_a >= 11'h10C && addr_a <= 11'h10E))) begin
        illegal_a++;
      end
    end
    if (b_only3 && rd_en_b) begin
      reads_b++;
      if (addr_b != 11'd3) illegal_b++;
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_a(input logic [31:0] w3, w2, w1, w0, input logic [6:0] s);
    exp_a.push_back('{data: {w3, w2, w1, w0}, slot: s});
  endtask

  task automatic push_b(input logic [31:0] w3, w2, w1, w0);
    exp_b.push_back('{data: {w3, w2, w1, w0}, slot: 7'd0});
  endtask

  task automatic write_slot_a(input int s, input logic [31:0] w0, w1, w2, w3);
    mem_a['h100 + s*4 + 0] = w0;
    mem_a['h100 + s*4 + 1] = w1;
    mem_a['h100 + s*4 + 2] = w2;
    mem_a['h100 + s*4 + 3] = w3;
  endtask

  task automatic drain_a(input string name, input int max);
    int c = 0;
    while (exp_a.size() != 0 && c < max) begin
      @(posedge clk);
      c++;
    end
    #2;
    check(name, exp_a.size(), 0);
  endtask

  task automatic drain_b(input string name, input int max);
    int c = 0;
    while (exp_b.size() != 0 && c < max) begin
      @(posedge clk);
      c++;
    end
    #2;
    check(name, exp_b.size(), 0);
  endtask

  // Returns at 1 time unit after the edge that launched the read.
  task automatic wait_read_a(input string name, input logic [10:0] a, input int max);
    int c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!(rd_en_a && addr_a == a) && c < max);
    check(name, (rd_en_a && addr_a == a), 1);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_data"},  data_a,  0);
    check({tag, "_slot"},  slot_a,  0);
    check({tag, "_rd_en"}, rd_en_a, 0);
    check({tag, "_addr"},  addr_a,  0);
    check({tag, "_busy"},  busy_a,  0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int c;
    int rd_seen;
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    enable_a = 1'b0; enable_b = 1'b0;
    accept_a = 1'b0; accept_b = 1'b0;
    cyc(3);

    // Reset state
    check_zero_a("rst_a");
    check("rst_b_valid", valid_b, 0);
    check("rst_b_rd_en", rd_en_b, 0);
    check("rst_b_busy",  busy_b,  0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    cyc(3);
    check("idle_a_busy",  busy_a,  0);
    check("idle_a_rd_en", rd_en_a, 0);

    // ---- B: first message, RD_LAT=2 latency = 5*3+1 ----
    mem_b[0] = 32'h1; mem_b[1] = 32'h2; mem_b[2] = 32'h3; mem_b[3] = 32'h8000_0004;
    push_b(32'h8000_0004, 32'h3, 32'h2, 32'h1);
    accept_b = 1'b1;
    enable_b = 1'b1;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!valid_b && c < 60);
    check("lat_b", c, 16);
    b_only3 = 1'b1;
    cyc(40);
    b_only3 = 1'b0;
    check("b_hdr_only", illegal_b, 0);
    check("b_polls", (reads_b > 0), 1);
    drain_b("drain_b1", 5);

    // Lead toggled to 0: new message; lead still 0: nothing
    mem_b[3] = 32'h0000_0005;
    push_b(32'h0000_0005, 32'h3, 32'h2, 32'h1);
    drain_b("drain_b2", 80);
    mem_b[3] = 32'h0000_0006;
    cyc(60);
    enable_b = 1'b0;

    // ---- A: latency 11 and backpressure ----
    write_slot_a(0, 32'h11, 32'h22, 32'h33, 32'h8000_00A0);
    push_a(32'h8000_00A0, 32'h33, 32'h22, 32'h11, 7'd0);
    enable_a = 1'b1;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!valid_a && c < 60);
    check("lat_a", c, 11);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", valid_a, 1);
      check("bp_data",  data_a, {32'h8000_00A0, 32'h33, 32'h22, 32'h11});
      check("bp_slot",  slot_a, 0);
      check("bp_rd_en", rd_en_a, 0);
    end
    #1;
    accept_a = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", valid_a, 0);
    drain_a("drain_bp", 5);

    // ---- A: ordering slot 1 then slot 3, read addresses ----
    #1;
    rst_n_a = 1'b0;
    mem_a['h103] = 32'h0;
    write_slot_a(1, 32'h111, 32'h112, 32'h113, 32'h8000_0114);
    write_slot_a(3, 32'h331, 32'h332, 32'h333, 32'h8000_0334);
    push_a(32'h8000_0114, 32'h113, 32'h112, 32'h111, 7'd1);
    push_a(32'h8000_0334, 32'h333, 32'h332, 32'h331, 7'd3);
    legal_on = 1'b1;
    cyc(1);
    rst_n_a = 1'b1;
    drain_a("drain_order", 200);
    cyc(20);
    legal_on = 1'b0;
    check("addr_legal", illegal_a, 0);
    check("hdr_all", hdr_seen, 4'hF);

    // ---- A: three torn reads on slot 2 ----
    torn_addr = 11'h10B;
    write_slot_a(2, 32'h221, 32'h222, 32'h223, 32'h8000_0224);
    push_a(32'h8000_0224, 32'h223, 32'h222, 32'h221, 7'd2);
    torn_req = torn_req + 6;
    drain_a("drain_torn3", 400);
    check("torn3_adv", after_torn_addr, 11'h10F);

    // ---- A: single torn read on slot 1 (lead 0 is new) ----
    torn_addr = 11'h107;
    write_slot_a(1, 32'h141, 32'h142, 32'h143, 32'h0000_0144);
    push_a(32'h0000_0144, 32'h143, 32'h142, 32'h141, 7'd1);
    torn_req = torn_req + 2;
    drain_a("drain_torn1", 300);
    check("torn1_reread", after_torn_addr, 11'h107);

    // ---- A: enable dropped during BODY ----
    write_slot_a(0, 32'hC1, 32'hC2, 32'hC3, 32'h8000_0C04);
    push_a(32'h8000_0C04, 32'hC3, 32'hC2, 32'hC1, 7'd0);
    wait_read_a("body_seen", 11'h101, 200);
    #1;
    enable_a = 1'b0;
    drain_a("drain_en", 50);
    cyc(3);
    check("en_drop_busy", busy_a, 0);
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rd_en_a) rd_seen++;
    end
    check("en_drop_no_rd", rd_seen, 0);

    // ---- A: reset during CHK, then redelivery ----
    #1;
    write_slot_a(1, 32'hE1, 32'hE2, 32'hE3, 32'h8000_0E04);
    enable_a = 1'b1;
    wait_read_a("w2_seen", 11'h106, 50);
    wait_read_a("chk_seen", 11'h107, 10);
    #2;
    rst_n_a = 1'b0;
    #1;
    check_zero_a("async_rst");
    push_a(32'h8000_0C04, 32'hC3,  32'hC2,  32'hC1,  7'd0);
    push_a(32'h8000_0E04, 32'hE3,  32'hE2,  32'hE1,  7'd1);
    push_a(32'h8000_0224, 32'h223, 32'h222, 32'h221, 7'd2);
    push_a(32'h8000_0334, 32'h333, 32'h332, 32'h331, 7'd3);
    cyc(1);
    rst_n_a = 1'b1;
    drain_a("drain_redeliver", 400);
    cyc(20);
    check("final_q_a", exp_a.size(), 0);
    check("final_q_b", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected completion");
    $fatal(1, "watchdog");
  end

endmodule
